// File: rtl/decomp_unpacker.sv
// decomp_unpacker: upstream feeder for the per-word decompressor.
//
// Consumes a packed 32-bit compressed stream made of groups. Each group is
// one header word of 2-bit size codes (code i at bits [2i+1:2i]) followed by
// byte-packed payload padded to a word boundary. For every code one
// (payload, code) pair is emitted, payload zero-extended to 32 bits.
//   code 00 = zero word, 01 = 1 byte, 10 = 2 bytes, 11 = 4 bytes raw.
//
// Parameters:
//   GROUP_WORDS  codes used per header (1..16)
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/in_valid/in_ready        packed stream input
//   out_data/out_bitmap/out_last/out_valid/out_ready  decoded output pairs
//
// Optional build macro DECOMP_UNPACK_STATS_EN adds saturating counters:
//   stat_words (output handshakes), stat_zero (handshakes with code 00),
//   stat_groups (completed groups).
module decomp_unpacker #(
  parameter int unsigned GROUP_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_bitmap,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
`ifdef DECOMP_UNPACK_STATS_EN
  ,
  output logic [31:0] stat_words,
  output logic [31:0] stat_zero,
  output logic [15:0] stat_groups
`endif
);

  typedef enum logic {HDR, PAY} state_t;

  localparam logic [3:0] LAST_IDX = 4'(GROUP_WORDS - 1);

  state_t      state;
  logic        run;         // sets on the first clock after reset release
  logic [31:0] hdr;
  logic [3:0]  code_idx;
  logic [4:0]  words_left;
  logic [3:0]  count;
  logic [63:0] bytes_q;     // byte 0 = buffer head; bytes at/above count are zero

  logic [1:0]  code;
  logic [2:0]  need;
  logic        fire;
  logic        last_fire;
  logic [3:0]  pop;
  logic [3:0]  count_after_pop;
  logic [3:0]  count_next;
  logic        push;
  logic        hdr_take;
  logic [31:0] payload;
  logic [63:0] bytes_next;

  function automatic logic [2:0] code_size(input logic [1:0] c);
    case (c)
      2'b00:   return 3'd0;
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [4:0] hdr_words(input logic [31:0] h);
    logic [6:0] total;
    total = '0;
    for (int unsigned i = 0; i < GROUP_WORDS; i++) begin
      total = total + 7'(code_size(h[2*i +: 2]));
    end
    return 5'((total + 7'd3) >> 2);
  endfunction

  always_comb begin
    code            = hdr[{code_idx, 1'b0} +: 2];
    need            = code_size(code);
    fire            = (state == PAY) && (4'(need) <= count) && (!out_valid || out_ready);
    last_fire       = fire && (code_idx == LAST_IDX);
    pop             = fire ? 4'(need) : '0;
    count_after_pop = count - pop;
    in_ready        = run && ((state == HDR) ||
                              ((words_left != '0) && (count_after_pop <= 4'd4)));
    push            = in_valid && in_ready && (state == PAY);
    hdr_take        = in_valid && in_ready && (state == HDR);
    count_next      = count_after_pop + (push ? 4'd4 : 4'd0);

    case (code)
      2'b00:   payload = '0;
      2'b01:   payload = {24'b0, bytes_q[7:0]};
      2'b10:   payload = {16'b0, bytes_q[15:0]};
      default: payload = bytes_q[31:0];
    endcase

    // Shift out the consumed bytes first, then drop the new word in at the
    // post-pop count; zeros above count make the OR a plain append.
    bytes_next = (bytes_q >> {pop, 3'b000}) |
                 (push ? ({32'b0, in_data} << {count_after_pop, 3'b000}) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HDR;
      run        <= 1'b0;
      hdr        <= '0;
      code_idx   <= '0;
      words_left <= '0;
      count      <= '0;
      bytes_q    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bitmap <= '0;
      out_last   <= 1'b0;
    end else begin
      run <= 1'b1;

      if (fire) begin
        out_valid  <= 1'b1;
        out_data   <= payload;
        out_bitmap <= code;
        out_last   <= (code_idx == LAST_IDX);
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end

      case (state)
        HDR: begin
          if (hdr_take) begin
            hdr        <= in_data;
            code_idx   <= '0;
            words_left <= hdr_words(in_data);
            count      <= '0;
            bytes_q    <= '0;
            state      <= PAY;
          end
        end
        PAY: begin
          // All payload words have arrived by the time the last code can
          // fire, so no push coincides with the end of a group.
          if (last_fire) begin
            count   <= '0;
            bytes_q <= '0;
            state   <= HDR;
          end else begin
            count   <= count_next;
            bytes_q <= bytes_next;
            if (fire) code_idx <= code_idx + 4'd1;
          end
          if (push) words_left <= words_left - 5'd1;
        end
        default: state <= HDR;
      endcase
    end
  end

`ifdef DECOMP_UNPACK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words  <= '0;
      stat_zero   <= '0;
      stat_groups <= '0;
    end else if (out_valid && out_ready) begin
      if (stat_words != '1) stat_words <= stat_words + 32'd1;
      if ((out_bitmap == 2'b00) && (stat_zero != '1)) stat_zero <= stat_zero + 32'd1;
      if (out_last && (stat_groups != '1)) stat_groups <= stat_groups + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decomp_unpacker.sv
module tb_decomp_unpacker;

  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_bitmap;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
`ifdef DECOMP_UNPACK_STATS_EN
  logic [31:0] stat_words;
  logic [31:0] stat_zero;
  logic [15:0] stat_groups;
`endif

  decomp_unpacker #(.GROUP_WORDS(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_bitmap (out_bitmap),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef DECOMP_UNPACK_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_zero  (stat_zero),
    .stat_groups(stat_groups)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  code;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] in_q[$];
  logic [31:0] pay_q[$];

  int n_pass = 0;
  int n_chk  = 0;
  int stall_left = 0;
  int e_words = 0, e_zero = 0, e_groups = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  function automatic int sz(input logic [1:0] c);
    return (c == 2'd0) ? 0 : (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : 4;
  endfunction

  // Reference model: flatten the payload to a byte queue and carve it per code.
  task automatic add_group(input logic [31:0] h, output int n_words);
    logic [7:0]  bq[$];
    logic [31:0] w;
    logic [31:0] d;
    logic [1:0]  c;
    int total = 0;
    for (int i = 0; i < G; i++) total += sz(2'(h >> (2 * i)));
    n_words = (total + 3) / 4;
    while (pay_q.size() < n_words) pay_q.push_back($urandom);
    in_q.push_back(h);
    for (int k = 0; k < n_words; k++) begin
      w = pay_q.pop_front();
      in_q.push_back(w);
      for (int b = 0; b < 4; b++) bq.push_back(8'(w >> (8 * b)));
    end
    pay_q.delete();
    for (int i = 0; i < G; i++) begin
      c = 2'(h >> (2 * i));
      d = '0;
      for (int b = 0; b < sz(c); b++) d = d | (32'(bq.pop_front()) << (8 * b));
      exp_q.push_back('{data: d, code: c, last: (i == G - 1)});
    end
  endtask

  task automatic drive(input bit rnd);
    in_valid  = (in_q.size() > 0) && (!rnd || ($urandom_range(0, 3) != 0));
    in_data   = (in_q.size() > 0) ? in_q[0] : $urandom;
    out_ready = (stall_left > 0) ? 1'b0 : (!rnd || ($urandom_range(0, 3) != 0));
  endtask

  task automatic run(input bit rnd, input int stop_after, input int stall, output int n_in);
    int cyc = 0;
    int n_out = 0;
    exp_t e;
    n_in = 0;
    stall_left = stall;
    drive(rnd);
    while ((in_q.size() > 0 || exp_q.size() > 0) &&
           (stop_after == 0 || n_out < stop_after) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stall_left > 0 && out_valid && exp_q.size() > 0) begin
        check("stall_hold", {out_data, out_bitmap}, {exp_q[0].data, exp_q[0].code});
        stall_left--;
        if (stall_left == 0) check("stall_in_ready_low", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", {out_data, out_bitmap, out_last}, 0);
          check("unexpected_output_flag", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("output", {out_data, out_bitmap, out_last}, {e.data, e.code, e.last});
          e_words++;
          if (e.code == 2'b00) e_zero++;
          if (e.last) e_groups++;
        end
      end
      if (in_valid && in_ready) begin
        void'(in_q.pop_front());
        n_in++;
      end
      @(posedge clk);
      #1;
      drive(rnd);
    end
    check("run_timeout", cyc >= 2000, 0);
    stall_left = 0;
  endtask

  initial begin
    int nw, ni;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_bitmap", out_bitmap, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;

    // mixed codes: 00, 01, 10, 11
    pay_q = '{32'h44332211, 32'h00776655};
    add_group(32'h0000_00E4, nw);
    check("t1_exp_words", nw, 2);
    run(0, 0, 0, ni);
    check("t1_in_handshakes", ni, 3);

    // all-zero group: header only
    add_group(32'h0000_0000, nw);
    run(0, 0, 0, ni);
    check("t2_in_handshakes", ni, 1);

    // four raw words with downstream stall of 5 cycles
    pay_q = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    add_group(32'h0000_00FF, nw);
    run(0, 0, 5, ni);
    check("t3_in_handshakes", ni, 5);

    // four 1-byte codes, then a clean second group
    pay_q = '{32'hDDCCBBAA};
    add_group(32'h0000_0055, nw);
    run(0, 0, 0, ni);
    check("t4_in_handshakes", ni, 2);
    add_group(32'h0000_00E4, nw);
    run(0, 0, 0, ni);
    check("t4b_in_handshakes", ni, 1 + nw);

    // reset mid-group after two outputs
    pay_q = '{32'hDDCCBBAA};
    add_group(32'h0000_0055, nw);
    run(0, 2, 0, ni);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    in_q.delete();
    e_words = 0; e_zero = 0; e_groups = 0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pay_q = '{32'h44332211, 32'h00776655};
    add_group(32'h0000_00E4, nw);
    run(0, 0, 0, ni);
    check("postrst_in_handshakes", ni, 3);

    // randomized headers (upper codes ignored), gaps and backpressure
    for (int g = 0; g < 30; g++) begin
      add_group($urandom, nw);
      run(1, 0, 0, ni);
      check("rand_in_handshakes", ni, 1 + nw);
    end

`ifdef DECOMP_UNPACK_STATS_EN
    @(negedge clk);
    check("stat_words", stat_words, e_words);
    check("stat_zero", stat_zero, e_zero);
    check("stat_groups", stat_groups, e_groups);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
